// File: rtl/imem_boot_sequencer_pkg.sv
// Shared types and constants for the instruction-memory boot sequencer.
package imem_boot_sequencer_pkg;

    localparam int unsigned ADDR_W_DEF = 11;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RUN   = 2'd3
    } state_e;

    // Top-bit opcode field of the core's instruction words.
    localparam logic [2:0] OP_ADD    = 3'b100;
    localparam logic [2:0] OP_BRANCH = 3'b101;
    localparam logic [2:0] OP_STORE  = 3'b110;
    localparam logic [2:0] OP_LOAD   = 3'b111;

endpackage

// File: rtl/boot_drain_timer.sv
// Loadable down-counter; done_c is high once the count has reached zero.
module boot_drain_timer #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load)                     cnt_d = load_val;
        else if (en && cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
    end

    assign done_c = (cnt_q == '0);

endmodule

// File: rtl/imem_boot_sequencer.sv
// Streams host instruction words into imem and gates cpu_en around loads.
module imem_boot_sequencer
    import imem_boot_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned DRAIN_CYCLES = 5,
    parameter int unsigned AUTO_RUN     = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_abort,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    output logic              w_enable,
    output logic [ADDR_W-1:0] w_adrs,
    output logic [DATA_W-1:0] w_instruction,
    output logic              cpu_en,
    output logic              busy,
    output logic [ADDR_W:0]   words_loaded,
    output logic              wrapped,
    output logic              err
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN    = LEN_W'(1) << ADDR_W;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    words_q, words_d;
    logic                wrapped_q, wrapped_d;
    logic                err_q, err_d;
    logic                w_enable_q, w_enable_d;
    logic [ADDR_W-1:0]   w_adrs_q, w_adrs_d;
    logic [DATA_W-1:0]   w_instr_q, w_instr_d;
    logic                cpu_en_q, cpu_en_d;
    logic                busy_q, busy_d;

    logic len_legal_c, beat_c, final_c, start_c, timer_load_c, drain_done_c;

    assign len_legal_c = (load_len != '0) && (load_len <= MAX_LEN);
    assign beat_c      = host_valid && (state_q == ST_LOAD) && !load_abort;
    assign final_c     = beat_c && ((words_q + LEN_W'(1)) == len_q);
    assign start_c     = load_start && ((state_q == ST_IDLE) || (state_q == ST_RUN));

    boot_drain_timer #(.CNT_W(CNT_W)) u_drain_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (timer_load_c),
        .load_val (DRAIN_LOAD),
        .en       (state_q == ST_DRAIN),
        .done_c   (drain_done_c)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            len_q      <= '0;
            words_q    <= '0;
            wrapped_q  <= 1'b0;
            err_q      <= 1'b0;
            w_enable_q <= 1'b0;
            w_adrs_q   <= '0;
            w_instr_q  <= '0;
            cpu_en_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            len_q      <= len_d;
            words_q    <= words_d;
            wrapped_q  <= wrapped_d;
            err_q      <= err_d;
            w_enable_q <= w_enable_d;
            w_adrs_q   <= w_adrs_d;
            w_instr_q  <= w_instr_d;
            cpu_en_q   <= cpu_en_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state: load_start outranks run_req/halt_req; abort outranks beats.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    if (len_legal_c) state_d = ST_LOAD;
                end else if (run_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (load_abort)   state_d = ST_IDLE;
                else if (final_c) state_d = (AUTO_RUN != 0) ? ST_RUN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (load_abort)        state_d = ST_IDLE;
                else if (drain_done_c) state_d = ST_LOAD;
            end
            ST_RUN: begin
                if (load_start) begin
                    if (len_legal_c) state_d = ST_DRAIN;
                end else if (halt_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_comb begin
        cur_d        = cur_q;
        len_d        = len_q;
        words_d      = words_q;
        wrapped_d    = wrapped_q;
        err_d        = err_q;
        w_enable_d   = 1'b0;
        w_adrs_d     = w_adrs_q;
        w_instr_d    = w_instr_q;
        timer_load_c = 1'b0;

        if (start_c) begin
            if (len_legal_c) begin
                cur_d        = load_base;
                len_d        = load_len;
                words_d      = '0;
                wrapped_d    = 1'b0;
                err_d        = 1'b0;
                timer_load_c = (state_q == ST_RUN);
            end else begin
                err_d = 1'b1;
            end
        end

        if (load_abort && ((state_q == ST_LOAD) || (state_q == ST_DRAIN))) err_d = 1'b1;

        if (beat_c) begin
            w_enable_d = 1'b1;
            w_adrs_d   = cur_q;
            w_instr_d  = host_data;
            cur_d      = cur_q + ADDR_W'(1);
            words_d    = words_q + LEN_W'(1);
            if (&cur_q) wrapped_d = 1'b1;
        end

        cpu_en_d = (state_d == ST_RUN);
        busy_d   = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    end

    assign host_ready    = (state_q == ST_LOAD);
    assign w_enable      = w_enable_q;
    assign w_adrs        = w_adrs_q;
    assign w_instruction = w_instr_q;
    assign cpu_en        = cpu_en_q;
    assign busy          = busy_q;
    assign words_loaded  = words_q;
    assign wrapped       = wrapped_q;
    assign err           = err_q;

endmodule
